// File: rtl/countdown_timer_pkg.sv
// -----------------------------------------------------------------------------
// countdown_timer_pkg
//   Shared definitions for the timer/counter family: FSM state encodings of the
//   countdown timer and the default datapath width used by the up-counters.
// -----------------------------------------------------------------------------
package countdown_timer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   typedef logic [1:0] timer_state_t;

   localparam timer_state_t StIdle   = 2'd0;
   localparam timer_state_t StArmed  = 2'd1;
   localparam timer_state_t StRun    = 2'd2;
   localparam timer_state_t StPaused = 2'd3;

endpackage

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Programmable down-counting timer. A period is loaded through a valid/ready
//   handshake, then the host starts, pauses, resumes or aborts the countdown.
//   A registered one-cycle `expired` pulse marks terminal count; with
//   auto-reload the period restarts immediately for periodic ticks.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   rst         in   synchronous active-high reset
//   load_valid  in   host offers a new period
//   load_ready  out  high only in IDLE
//   load_value  in   period N (N = 0 behaves as N = 1)
//   load_auto   in   auto-reload enable, latched with the load
//   start       in   level, ARMED->RUN and PAUSED->RUN
//   pause       in   level, RUN->PAUSED
//   stop        in   abort, any non-IDLE state returns to IDLE
//   count       out  current count (registered)
//   expired     out  registered one-cycle terminal-count pulse
//   busy        out  high whenever the state is not IDLE
// -----------------------------------------------------------------------------
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             load_auto,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             expired,
   output logic             busy
);

   timer_state_t     state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_reg_q, reload_reg_d;
   logic             auto_reg_q, auto_reg_d;
   logic             expired_q, expired_d;
   logic             terminal;

   // Treating 0 like 1 makes a zero period expire after one RUN cycle and keeps
   // the decrement from ever wrapping.
   assign terminal = (count_q <= WIDTH'(1));

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      reload_reg_d = reload_reg_q;
      auto_reg_d   = auto_reg_q;
      expired_d    = 1'b0;

      case (state_q)
         StIdle: begin
            if (load_valid) begin
               count_d      = load_value;
               reload_reg_d = load_value;
               auto_reg_d   = load_auto;
               state_d      = StArmed;
            end
         end

         StArmed: begin
            if (stop) begin
               count_d = '0;
               state_d = StIdle;
            end else if (start) begin
               state_d = StRun;
            end
         end

         StRun: begin
            if (stop) begin
               count_d = '0;
               state_d = StIdle;
            end else if (pause) begin
               // Pause beats terminal count: the expiry is deferred, not lost.
               state_d = StPaused;
            end else if (terminal) begin
               expired_d = 1'b1;
               if (auto_reg_q) begin
                  count_d = reload_reg_q;
               end else begin
                  count_d = '0;
                  state_d = StIdle;
               end
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end

         StPaused: begin
            if (stop) begin
               count_d = '0;
               state_d = StIdle;
            end else if (start) begin
               state_d = StRun;
            end
         end

         default: begin
            count_d = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         count_q      <= '0;
         reload_reg_q <= '0;
         auto_reg_q   <= 1'b0;
         expired_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         reload_reg_q <= reload_reg_d;
         auto_reg_q   <= auto_reg_d;
         expired_q    <= expired_d;
      end
   end

   assign load_ready = (state_q == StIdle);
   assign busy       = (state_q != StIdle);
   assign count      = count_q;
   assign expired    = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

   localparam int unsigned WIDTH = 32;

   logic             clk;
   logic             rst;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_value;
   logic             load_auto;
   logic             start;
   logic             pause;
   logic             stop;
   logic [WIDTH-1:0] count;
   logic             expired;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   countdown_timer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_value (load_value),
      .load_auto  (load_auto),
      .start      (start),
      .pause      (pause),
      .stop       (stop),
      .count      (count),
      .expired    (expired),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Outputs are sampled 1 time unit after the edge; inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [WIDTH-1:0] value, input logic auto_en);
      load_valid = 1'b1;
      load_value = value;
      load_auto  = auto_en;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; load_valid = 1'b0; load_value = '0; load_auto = 1'b0;
      start = 1'b0; pause = 1'b0; stop = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      n_checks++; if (count !== 32'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", count); end
      n_checks++; if (expired !== 1'b0) begin n_errors++; $display("FAIL reset_expired got %b want 0", expired); end
      n_checks++; if (load_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b want 1", load_ready); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end

      do_load(32'd3, 1'b0);
      n_checks++; if (count !== 32'd3) begin n_errors++; $display("FAIL load_count got %0d want 3", count); end
      n_checks++; if (busy !== 1'b1 || load_ready !== 1'b0) begin n_errors++; $display("FAIL armed_flags got busy=%b ready=%b want busy=1 ready=0", busy, load_ready); end
      do_start();
      n_checks++; if (count !== 32'd3 || expired !== 1'b0) begin n_errors++; $display("FAIL start_count got %0d/%b want 3/0", count, expired); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks++; if (count !== 32'(3 - i)) begin n_errors++; $display("FAIL basic_count i=%0d got %0d want %0d", i, count, 3 - i); end
         n_checks++; if (expired !== (i == 3)) begin n_errors++; $display("FAIL basic_expired i=%0d got %b want %b", i, expired, (i == 3)); end
      end
      n_checks++; if (busy !== 1'b0 || load_ready !== 1'b1) begin n_errors++; $display("FAIL basic_done got busy=%b ready=%b want busy=0 ready=1", busy, load_ready); end
      tick();
      n_checks++; if (expired !== 1'b0) begin n_errors++; $display("FAIL basic_single_pulse got %b want 0", expired); end
   endtask

   task automatic test_auto_reload();
      logic [WIDTH-1:0] exp_count;
      do_load(32'd4, 1'b1);
      do_start();
      for (int i = 1; i <= 12; i++) begin
         tick();
         exp_count = ((i % 4) == 0) ? 32'd4 : 32'(4 - (i % 4));
         n_checks++; if (count !== exp_count) begin n_errors++; $display("FAIL auto_count i=%0d got %0d want %0d", i, count, exp_count); end
         n_checks++; if (expired !== ((i % 4) == 0)) begin n_errors++; $display("FAIL auto_expired i=%0d got %b want %b", i, expired, ((i % 4) == 0)); end
         n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL auto_busy i=%0d got %b want 1", i, busy); end
      end
      do_stop();
      n_checks++; if (busy !== 1'b0 || count !== 32'd0 || expired !== 1'b0) begin n_errors++; $display("FAIL auto_stop got busy=%b count=%0d exp=%b want 0/0/0", busy, count, expired); end
   endtask

   task automatic test_pause_resume();
      do_load(32'd10, 1'b0);
      do_start();
      repeat (4) tick();
      n_checks++; if (count !== 32'd6) begin n_errors++; $display("FAIL pause_pre got %0d want 6", count); end
      pause = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (count !== 32'd6 || expired !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL pause_hold i=%0d got count=%0d exp=%b busy=%b want 6/0/1", i, count, expired, busy); end
      end
      pause = 1'b0;
      do_start();
      n_checks++; if (count !== 32'd6) begin n_errors++; $display("FAIL resume_count got %0d want 6", count); end
      for (int j = 1; j <= 6; j++) begin
         tick();
         n_checks++; if (count !== 32'(6 - j) || expired !== (j == 6)) begin n_errors++; $display("FAIL resume_run j=%0d got count=%0d exp=%b want %0d/%b", j, count, expired, 6 - j, (j == 6)); end
      end
   endtask

   task automatic test_abort_collisions();
      // Stop in RUN at count 2.
      do_load(32'd5, 1'b0);
      do_start();
      repeat (3) tick();
      n_checks++; if (count !== 32'd2) begin n_errors++; $display("FAIL abort_pre got %0d want 2", count); end
      do_stop();
      n_checks++; if (count !== 32'd0 || busy !== 1'b0 || expired !== 1'b0) begin n_errors++; $display("FAIL abort_run got count=%0d busy=%b exp=%b want 0/0/0", count, busy, expired); end
      tick();
      n_checks++; if (expired !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL abort_after got exp=%b busy=%b want 0/0", expired, busy); end

      // Start and stop together in ARMED.
      do_load(32'd5, 1'b0);
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      n_checks++; if (busy !== 1'b0 || count !== 32'd0 || load_ready !== 1'b1) begin n_errors++; $display("FAIL armed_collide got busy=%b count=%0d ready=%b want 0/0/1", busy, count, load_ready); end
      tick();
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL armed_collide_after got busy=%b want 0", busy); end

      // Pause in the terminal cycle defers the expiry.
      do_load(32'd2, 1'b0);
      do_start();
      tick();
      n_checks++; if (count !== 32'd1) begin n_errors++; $display("FAIL term_pre got %0d want 1", count); end
      pause = 1'b1;
      tick();
      n_checks++; if (count !== 32'd1 || expired !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL term_pause got count=%0d exp=%b busy=%b want 1/0/1", count, expired, busy); end
      tick();
      n_checks++; if (expired !== 1'b0) begin n_errors++; $display("FAIL term_pause_held got %b want 0", expired); end
      pause = 1'b0;
      do_start();
      n_checks++; if (count !== 32'd1 || expired !== 1'b0) begin n_errors++; $display("FAIL term_resume got count=%0d exp=%b want 1/0", count, expired); end
      tick();
      n_checks++; if (count !== 32'd0 || expired !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL term_expire got count=%0d exp=%b busy=%b want 0/1/0", count, expired, busy); end
   endtask

   task automatic test_edge_periods();
      // Zero period with auto-reload pulses every RUN cycle.
      do_load(32'd0, 1'b1);
      do_start();
      n_checks++; if (expired !== 1'b0) begin n_errors++; $display("FAIL zero_start got %b want 0", expired); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (expired !== 1'b1 || count !== 32'd0) begin n_errors++; $display("FAIL zero_auto i=%0d got exp=%b count=%0d want 1/0", i, expired, count); end
      end
      do_stop();

      // Maximum period: first decrement.
      do_load(32'hFFFF_FFFF, 1'b0);
      n_checks++; if (count !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL max_load got %h want ffffffff", count); end
      do_start();
      tick();
      n_checks++; if (count !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL max_dec got %h want fffffffe", count); end
      do_stop();

      // Load offered while busy is refused; the latched period and auto flag survive.
      do_load(32'd3, 1'b1);
      do_start();
      load_valid = 1'b1; load_value = 32'd7; load_auto = 1'b0;
      n_checks++; if (load_ready !== 1'b0) begin n_errors++; $display("FAIL busy_ready got %b want 0", load_ready); end
      tick();
      tick();
      load_valid = 1'b0;
      n_checks++; if (count !== 32'd1) begin n_errors++; $display("FAIL busy_load got %0d want 1", count); end
      tick();
      n_checks++; if (count !== 32'd3 || expired !== 1'b1 || busy !== 1'b1) begin n_errors++; $display("FAIL busy_reload got count=%0d exp=%b busy=%b want 3/1/1", count, expired, busy); end
      do_stop();
   endtask

   task automatic test_back_to_back();
      do_load(32'd2, 1'b0);
      do_start();
      tick();
      tick();
      n_checks++; if (expired !== 1'b1 || load_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_expire got exp=%b ready=%b want 1/1", expired, load_ready); end
      do_load(32'd3, 1'b0);
      n_checks++; if (count !== 32'd3 || busy !== 1'b1 || expired !== 1'b0) begin n_errors++; $display("FAIL b2b_load got count=%0d busy=%b exp=%b want 3/1/0", count, busy, expired); end
      do_start();
      repeat (2) tick();
      n_checks++; if (expired !== 1'b0) begin n_errors++; $display("FAIL b2b_early got %b want 0", expired); end
      tick();
      n_checks++; if (expired !== 1'b1 || count !== 32'd0) begin n_errors++; $display("FAIL b2b_second got exp=%b count=%0d want 1/0", expired, count); end
   endtask

   task automatic test_mid_reset();
      do_load(32'd8, 1'b0);
      do_start();
      repeat (3) tick();
      n_checks++; if (count !== 32'd5) begin n_errors++; $display("FAIL midrst_pre got %0d want 5", count); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (count !== 32'd0 || expired !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_state got count=%0d exp=%b busy=%b ready=%b want 0/0/0/1", count, expired, busy, load_ready); end
      tick();
      n_checks++; if (expired !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL midrst_after got exp=%b busy=%b want 0/0", expired, busy); end
      do_load(32'd2, 1'b0);
      do_start();
      tick();
      n_checks++; if (count !== 32'd1 || expired !== 1'b0) begin n_errors++; $display("FAIL midrst_run got count=%0d exp=%b want 1/0", count, expired); end
      tick();
      n_checks++; if (count !== 32'd0 || expired !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL midrst_expire got count=%0d exp=%b busy=%b want 0/1/0", count, expired, busy); end
   endtask

   initial begin
      test_reset();
      test_auto_reload();
      test_pause_resume();
      test_abort_collisions();
      test_edge_periods();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Programmable down-counting timer, the counterpart to the free-running up-counter used throughout the design. A host loads a period through a valid/ready handshake, then starts, pauses, resumes or aborts the countdown. The block emits a one-cycle `expired` pulse at terminal count and can reload automatically for periodic ticks. It sits next to the up-counters as the event and timeout source for control logic.

## Interface
- `WIDTH`, 32, bit width of the period and the count.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load_valid`  in  1  host offers a new period.
- `load_ready`  out  1  high only in IDLE; a load is accepted when `load_valid` and `load_ready` are both high at a clock edge.
- `load_value`  in  WIDTH  period N; sampled with the load.
- `load_auto`  in  1  auto-reload enable; latched with the load.
- `start`  in  1  level; ARMED→RUN and PAUSED→RUN.
- `pause`  in  1  level; RUN→PAUSED.
- `stop`  in  1  abort; any non-IDLE state goes to IDLE.
- `count`  out  WIDTH  current count, registered.
- `expired`  out  1  registered one-cycle pulse at terminal count.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, ARMED, RUN, PAUSED.
- **Internal registers:** `reload_reg` (WIDTH bits), `auto_reg` (1 bit).
- **IDLE:**
  - On an accepted load: `count` ← `load_value`, `reload_reg` ← `load_value`, `auto_reg` ← `load_auto`; go to ARMED.
  - `start`, `pause` and `stop` are ignored.
- **ARMED:**
  - `stop` → IDLE, `count` ← 0.
  - Otherwise `start` → RUN, `count` unchanged.
  - `pause` has no effect.
- **RUN, priority order `stop` > `pause` > count:**
  - `stop` → IDLE, `count` ← 0, no pulse.
  - `pause` → PAUSED, `count` held.
  - Terminal (`count` is 1 or 0):
    - `expired` ← 1.
    - If `auto_reg`: `count` ← `reload_reg`, stay in RUN.
    - Else: `count` ← 0, go to IDLE.
  - Otherwise `count` ← `count` − 1.
- **PAUSED:**
  - `stop` → IDLE, `count` ← 0.
  - Else `start` → RUN.
  - Else hold.
  - A held `pause` has no effect here.
- **Arithmetic:** decrement is WIDTH-bit unsigned. The terminal check at 1/0 guarantees `count` never wraps.
- **Period:** N cycles of RUN per expiry for N ≥ 1. N = 0 behaves as N = 1; with auto-reload, `expired` then pulses every RUN cycle.
- **Pause and terminal together:** if `pause` is high in the terminal cycle, `pause` wins, the expiry is deferred, and the count stays at its held value.
- **`expired`:** low in every cycle except the one following a terminal edge. Two pulses are never merged.

## Timing
- **Reset:** while `rst` is high at an edge, the next state is IDLE with `count` = 0 and `expired` = 0. `reload_reg` and `auto_reg` are cleared.
- **Reset mid-run:** no `expired` pulse is issued.
- **Outputs after reset:** `load_ready` = 1, `busy` = 0.
- **Load:** `count` shows the loaded value one cycle after the accepting edge.
- **Start latency:** the edge that samples `start` enters RUN. The first decrement happens on the following edge.
- **Non-auto expiry:** `expired` is high exactly N cycles after the start edge, in the same cycle that `count` = 0 and `busy` = 0.
- **Decoded outputs:** `load_ready` and `busy` are decoded from the state register, so they change in the cycle after the transition edge.
- **Back-to-back:** a new load is accepted in the first IDLE cycle after expiry, i.e. the same cycle `expired` is high.

## Structure
- **Shared package:** the state enum (IDLE, ARMED, RUN, PAUSED) and the default `WIDTH` constant (32), shared with the up-counters.
- **Sub-modules:** none. The FSM and datapath form a single module of about 150 lines.

## Test plan
- **Reset:** reset, then `load_value` = 3 with `load_auto` = 0, then `start` for one cycle. Expect `count` 3, 2, 1, 0, with `expired` high for one cycle exactly 3 cycles after the start edge, then `busy` = 0 and `load_ready` = 1.
- **Auto-reload:** load 4 with `load_auto` = 1, then start. Expect `expired` every 4 cycles and `count` sequence 4, 3, 2, 1, 4, 3, … for at least 3 periods.
- **Pause/resume:** load 10, start, assert `pause` at `count` = 6 for 5 cycles, then `start`. Expect `count` held at 6 throughout the pause and `expired` 6 cycles after resume.
- **Abort and collisions:**
  - `stop` at `count` = 2 in RUN gives IDLE, `count` = 0, and no `expired`.
  - `start` and `stop` together in ARMED gives IDLE.
  - `pause` in the terminal cycle defers `expired`.
- **Edge periods:**
  - Load 0 with auto: `expired` every cycle in RUN.
  - Load 0xFFFFFFFF with no auto: check the first decrement to 0xFFFFFFFE.
  - `load_valid` while busy: not accepted, `reload_reg` unchanged.
- **Mid-run reset:** assert `rst` at `count` = 5 in RUN. Expect `count` = 0, IDLE, no pulse; a subsequent load of 2 then works normally.
